// File: rtl/mem_access_sequencer.sv
// Handshake sequencer sharing one variable-latency memory port between fetch and load/store.
// Optional request timeout is compiled in with `define MEM_SEQ_TIMEOUT_EN.
module mem_access_sequencer #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] data_addr,
    input  logic [3:0]  where2write,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    output logic [31:0] instr_out,
    output logic [31:0] load_data,
    output logic        commit,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0] state_r;
    logic [2:0] next_state_s;
    logic       req_s;
    logic       commit_s;
    logic       timeout_s;

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt_r;
    logic          req_state_s;

    assign req_state_s = (state_r == S_FETCH) || (state_r == S_LOAD) || (state_r == S_STORE);
    // Abort fires on the cycle the counter would reach the limit.
    assign timeout_s   = req_state_s && !mem_ready && (wait_cnt_r == CW'(TIMEOUT_CYCLES - 1));

    // Wait counter: zero outside request states so each request starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (!req_state_s || mem_ready || timeout_s) begin
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (timeout_s) begin
            err <= 1'b1;
        end else begin
            err <= err;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a store wins when both load and store are decoded.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH:  next_state_s = (mem_ready || timeout_s) ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (mem_w) begin
                    next_state_s = S_STORE;
                end else if (mem_r) begin
                    next_state_s = S_LOAD;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_LOAD:   next_state_s = (mem_ready || timeout_s) ? S_COMMIT : S_LOAD;
            S_STORE:  next_state_s = (mem_ready || timeout_s) ? S_COMMIT : S_STORE;
            S_COMMIT: next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Memory port and commit decode; request fields are zero outside request states.
    always_comb begin
        req_s     = 1'b0;
        commit_s  = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_we    = 4'b0000;
        mem_wdata = 32'h0000_0000;
        case (state_r)
            S_FETCH: begin
                req_s    = 1'b1;
                mem_addr = pc;
            end
            S_DECODE: commit_s = !mem_r && !mem_w;
            S_LOAD: begin
                req_s    = 1'b1;
                mem_addr = data_addr;
            end
            S_STORE: begin
                req_s     = 1'b1;
                mem_addr  = data_addr;
                mem_we    = where2write;
                mem_wdata = store_data;
            end
            S_COMMIT: commit_s = 1'b1;
            default: begin
                req_s    = 1'b0;
                commit_s = 1'b0;
            end
        endcase
    end

    // Reset gates the request and commit immediately, without waiting for a clock.
    assign mem_req = req_s && !rst;
    assign commit  = commit_s && !rst;
    assign busy    = (state_r != S_DECODE);

    // Holding registers for the fetched instruction and the raw load word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_out <= NOP_INSTR;
            load_data <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (mem_ready) begin
                        instr_out <= mem_rdata;
                    end else if (timeout_s) begin
                        instr_out <= NOP_INSTR;
                    end else begin
                        instr_out <= instr_out;
                    end
                end
                S_LOAD: begin
                    if (mem_ready) begin
                        load_data <= mem_rdata;
                    end else if (timeout_s) begin
                        load_data <= 32'h0000_0000;
                    end else begin
                        load_data <= load_data;
                    end
                end
                default: begin
                    instr_out <= instr_out;
                    load_data <= load_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: directed instructions push expected memory
// transactions and commits; a negedge monitor pops and compares them.
module tb_mem_access_sequencer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        mem_r = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] data_addr = 32'h0;
    logic [3:0]  where2write = 4'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] instr_out;
    logic [31:0] load_data;
    logic        commit;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] ld;
    } cmt_t;

    txn_t txn_q[$];
    cmt_t cmt_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_access_sequencer #(.TIMEOUT_CYCLES(4), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .mem_r(mem_r), .mem_w(mem_w),
        .data_addr(data_addr), .where2write(where2write), .store_data(store_data),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .instr_out(instr_out), .load_data(load_data), .commit(commit),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: completed handshakes and commit pulses are matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_ready) begin
                if (txn_q.size() == 0) begin
                    chk("unexpected_txn", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    txn_t t;
                    t = txn_q.pop_front();
                    chk("txn_addr", mem_addr, t.addr);
                    chk("txn_we", {28'h0, mem_we}, {28'h0, t.we});
                    chk("txn_wdata", mem_wdata, t.wdata);
                end
            end
            if (commit) begin
                if (cmt_q.size() == 0) begin
                    chk("unexpected_commit", instr_out, 32'hFFFF_FFFF);
                end else begin
                    cmt_t c;
                    c = cmt_q.pop_front();
                    chk("commit_instr", instr_out, c.instr);
                    chk("commit_load", load_data, c.ld);
                end
            end
        end
    end

    // Checks one cycle's control outputs at the negedge, then advances to just after the next posedge.
    task automatic cyc(input logic e_req, input logic e_commit, input logic e_busy,
                       input logic [31:0] e_addr, input logic [3:0] e_we);
        @(negedge clk);
        chk("mem_req", {31'h0, mem_req}, {31'h0, e_req});
        chk("commit", {31'h0, commit}, {31'h0, e_commit});
        chk("busy", {31'h0, busy}, {31'h0, e_busy});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", {28'h0, mem_we}, {28'h0, e_we});
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] pcv, input logic [31:0] instr,
                             input logic r, input logic w, input logic [31:0] daddr,
                             input logic [3:0] be, input logic [31:0] sdata,
                             input logic [31:0] rd, input int fw, input int mw,
                             input logic [31:0] exp_ld);
        txn_t       t;
        cmt_t       c;
        logic [3:0] we_e;
        we_e = w ? be : 4'h0;
        pc = pcv; mem_r = r; mem_w = w; data_addr = daddr;
        where2write = be; store_data = sdata;
        t.addr = pcv; t.we = 4'h0; t.wdata = 32'h0;
        txn_q.push_back(t);
        c.instr = instr; c.ld = exp_ld;
        cmt_q.push_back(c);
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0; mem_rdata = 32'hBAD0BAD0;
            cyc(1'b1, 1'b0, 1'b1, pcv, 4'h0);
        end
        mem_ready = 1'b1; mem_rdata = instr;
        cyc(1'b1, 1'b0, 1'b1, pcv, 4'h0);
        // mem_ready held high outside request states must be ignored
        mem_rdata = 32'h5A5A5A5A;
        if (r || w) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
            t.addr = daddr; t.we = we_e; t.wdata = w ? sdata : 32'h0;
            txn_q.push_back(t);
            for (int i = 0; i < mw; i++) begin
                mem_ready = 1'b0;
                cyc(1'b1, 1'b0, 1'b1, daddr, we_e);
            end
            mem_ready = 1'b1; mem_rdata = rd;
            cyc(1'b1, 1'b0, 1'b1, daddr, we_e);
            mem_rdata = 32'h5A5A5A5A;
            cyc(1'b0, 1'b1, 1'b1, 32'h0, 4'h0);
        end else begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        txn_t t;
        cmt_t c;
        // Reset state
        @(negedge clk);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_load", load_data, 32'h0);
        chk("rst_commit", {31'h0, commit}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // addi zero-wait, load with 2 waits, store, load+store conflict, zero-wait load
        run_instr(32'h0,  32'h00500093, 1'b0, 1'b0, 32'h0,   4'h0,    32'h0,        32'h0,        0, 0, 32'h0);
        run_instr(32'h4,  32'h10002083, 1'b1, 1'b0, 32'h100, 4'h0,    32'h0,        32'hDEADBEEF, 0, 2, 32'hDEADBEEF);
        run_instr(32'h8,  32'h00B10123, 1'b0, 1'b1, 32'h102, 4'b0100, 32'h00AB0000, 32'h77777777, 1, 2, 32'hDEADBEEF);
        run_instr(32'hC,  32'h12345678, 1'b1, 1'b1, 32'h200, 4'b1111, 32'hCAFEF00D, 32'h11111111, 0, 1, 32'hDEADBEEF);
        run_instr(32'h10, 32'h00402103, 1'b1, 1'b0, 32'h104, 4'h0,    32'h0,        32'h0BADF00D, 0, 0, 32'h0BADF00D);

        // Reset in the middle of a waiting load
        pc = 32'h14; mem_r = 1'b1; mem_w = 1'b0; data_addr = 32'h300;
        t.addr = 32'h14; t.we = 4'h0; t.wdata = 32'h0;
        txn_q.push_back(t);
        mem_ready = 1'b1; mem_rdata = 32'h00002183;
        cyc(1'b1, 1'b0, 1'b1, 32'h14, 4'h0);
        mem_ready = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'h300, 4'h0);
        rst = 1'b1;
        #1;
        chk("rstmid_req", {31'h0, mem_req}, 32'h0);
        chk("rstmid_commit", {31'h0, commit}, 32'h0);
        chk("rstmid_instr", instr_out, NOP);
        chk("rstmid_load", load_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; mem_r = 1'b0;
        run_instr(32'h24, 32'h00100013, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

`ifdef MEM_SEQ_TIMEOUT_EN
        // Fetch stuck for 4 cycles aborts to a NOP and sets the sticky error
        pc = 32'h28; mem_r = 1'b0; mem_w = 1'b0;
        c.instr = NOP; c.ld = 32'h0;
        cmt_q.push_back(c);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'h28, 4'h0);
        end
        @(negedge clk);
        chk("to_instr", instr_out, NOP);
        chk("to_err", {31'h0, err}, 32'h1);
        @(posedge clk);
        #1;
        run_instr(32'h2C, 32'h00300093, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        chk("to_err_sticky", {31'h0, err}, 32'h1);
        rst = 1'b1;
        #1;
        chk("to_err_cleared", {31'h0, err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`else
        chk("err_tied_low", {31'h0, err}, 32'h0);
`endif

        repeat (2) @(posedge clk);
        chk("txn_q_empty", txn_q.size(), 32'h0);
        chk("cmt_q_empty", cmt_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
